// File: rtl/acs4.sv
// acs4 - four-state add-compare-select unit for the K=3, rate-1/2 (7,5)
// Viterbi decoder, with hard-decision branch metrics computed inline.
// Each accepted symbol pair is one trellis step. The step produces one
// decision bit per state and four normalized, saturated 4-bit path metrics,
// all registered and handed straight to the survivor-path decoder.

module acs4 (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic       sof,
   input  logic       sym0,
   input  logic       sym1,
   output logic       d0,
   output logic       d1,
   output logic       d2,
   output logic       d3,
   output logic [3:0] pm0,
   output logic [3:0] pm1,
   output logic [3:0] pm2,
   output logic [3:0] pm3,
   output logic       out_valid
);

   // Registered path metrics and decisions
   logic [3:0] pmq [4];
   logic [3:0] dq;

   // Metric vector feeding the current step (registered, or the frame-start vector)
   logic [3:0] oldpm [4];

   // Selected (pre-normalization) survivor metrics and their decisions
   logic [4:0] selpm [4];
   logic [3:0] dnext;

   // Smallest selected metric, used to rebase all four
   logic [4:0] min01;
   logic [4:0] min23;
   logic [4:0] minpm;

   // Normalized, saturated metrics to be registered
   logic [3:0] pmnext [4];

   // Hamming distance between the received pair and the code bits that the
   // (7,5) encoder emits when input u is shifted in on top of register p.
   function automatic logic [1:0] branchmetric(input logic u,
                                               input logic [1:0] p,
                                               input logic r0,
                                               input logic r1);
      logic c0;
      logic c1;
      c0 = u ^ p[1] ^ p[0];
      c1 = u ^ p[0];
      return {1'b0, r0 ^ c0} + {1'b0, r1 ^ c1};
   endfunction

   // A frame start restarts the trellis from state 0, ignoring the registers
   always_comb begin
      if (sof) begin
         oldpm[0] = 4'd0;
         oldpm[1] = 4'd7;
         oldpm[2] = 4'd7;
         oldpm[3] = 4'd7;
      end else begin
         oldpm[0] = pmq[0];
         oldpm[1] = pmq[1];
         oldpm[2] = pmq[2];
         oldpm[3] = pmq[3];
      end
   end

   // One ACS butterfly half per new state {u,a}: predecessors are {a,0} and
   // {a,1}. Only a strictly smaller {a,1} candidate wins, so ties pick {a,0}.
   for (genvar n = 0; n < 4; n++) begin : g_acs
      localparam logic [1:0] NS = 2'(n);
      localparam logic [1:0] PA = {NS[0], 1'b0};
      localparam logic [1:0] PB = {NS[0], 1'b1};

      logic [4:0] canda;
      logic [4:0] candb;

      assign canda = {1'b0, oldpm[PA]} + {3'b000, branchmetric(NS[1], PA, sym0, sym1)};
      assign candb = {1'b0, oldpm[PB]} + {3'b000, branchmetric(NS[1], PB, sym0, sym1)};

      assign dnext[n] = (candb < canda);
      assign selpm[n] = (candb < canda) ? candb : canda;
   end

   // Minimum of the four survivors, as a two-level compare tree
   always_comb begin
      min01 = (selpm[1] < selpm[0]) ? selpm[1] : selpm[0];
      min23 = (selpm[3] < selpm[2]) ? selpm[3] : selpm[2];
      minpm = (min23 < min01) ? min23 : min01;
   end

   // Rebase every survivor on the minimum and clamp to the 4-bit range
   for (genvar n = 0; n < 4; n++) begin : g_norm
      logic [4:0] diff;
      assign diff      = selpm[n] - minpm;
      assign pmnext[n] = (diff > 5'd15) ? 4'd15 : diff[3:0];
   end

   // State update: reset wins, otherwise load a new step only when a symbol
   // is accepted so outputs hold across idle cycles
   always_ff @(posedge clk) begin
      if (!reset) begin
         pmq[0]    <= 4'd0;
         pmq[1]    <= 4'd7;
         pmq[2]    <= 4'd7;
         pmq[3]    <= 4'd7;
         dq        <= 4'b0000;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            pmq[0] <= pmnext[0];
            pmq[1] <= pmnext[1];
            pmq[2] <= pmnext[2];
            pmq[3] <= pmnext[3];
            dq     <= dnext;
         end
      end
   end

   assign pm0 = pmq[0];
   assign pm1 = pmq[1];
   assign pm2 = pmq[2];
   assign pm3 = pmq[3];
   assign d0  = dq[0];
   assign d1  = dq[1];
   assign d2  = dq[2];
   assign d3  = dq[3];

endmodule

// File: tb/tb_acs4.sv
// tb_acs4 - directed vector table plus a long randomized run against a
// forward-walking trellis reference for the acs4 ACS unit.

module tb_acs4;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       sof;
   logic       sym0;
   logic       sym1;
   logic       d0, d1, d2, d3;
   logic [3:0] pm0, pm1, pm2, pm3;
   logic       out_valid;

   int nChecks;
   int nFails;

   // Reference metrics and decisions for the randomized run
   int refPm [4];
   int refD  [4];

   // One directed vector: inputs for a cycle and the outputs expected after it.
   // Metrics are packed {pm0,pm1,pm2,pm3}, decisions {d0,d1,d2,d3}.
   typedef struct {
      logic        rstn;
      logic        iv;
      logic        sf;
      logic        s0;
      logic        s1;
      logic        expOv;
      logic [15:0] expPm;
      logic [3:0]  expD;
   } vec_t;

   vec_t vecs [21];

   acs4 dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .sof       (sof),
      .sym0      (sym0),
      .sym1      (sym1),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .pm0       (pm0),
      .pm1       (pm1),
      .pm2       (pm2),
      .pm3       (pm3),
      .out_valid (out_valid)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, then move 1 unit past the rising edge
   task automatic applyStimulus(input logic rstn, input logic iv, input logic sf,
                                input logic s0, input logic s1);
      reset    = rstn;
      in_valid = iv;
      sof      = sf;
      sym0     = s0;
      sym1     = s1;
      @(posedge clk);
      #1;
   endtask

   // Compare out_valid, metrics and decisions against expectations
   task automatic checkOutput(input string name, input logic expOv,
                              input logic [15:0] expPm, input logic [3:0] expD);
      logic [15:0] gotPm;
      logic [3:0]  gotD;
      gotPm = {pm0, pm1, pm2, pm3};
      gotD  = {d0, d1, d2, d3};
      nChecks++;
      if (out_valid !== expOv) begin
         nFails++;
         $display("[TB] FAIL %s out_valid: got %b expected %b", name, out_valid, expOv);
      end
      nChecks++;
      if (gotPm !== expPm) begin
         nFails++;
         $display("[TB] FAIL %s pm0..pm3: got %h expected %h", name, gotPm, expPm);
      end
      nChecks++;
      if (gotD !== expD) begin
         nFails++;
         $display("[TB] FAIL %s d0..d3: got %b expected %b", name, gotD, expD);
      end
   endtask

   // Reference step: walk every (old state, input bit) edge forward through
   // the encoder shift register and keep the best arrival per new state.
   // Old states are visited in ascending order, so with a strict compare a tie
   // keeps the predecessor whose LSB is 0.
   task automatic modelStep(input logic s0, input logic s1, input logic sf);
      int oldv [4];
      int best [4];
      int bestp0 [4];
      int mn;
      for (int i = 0; i < 4; i++) begin
         oldv[i]   = sf ? ((i == 0) ? 0 : 7) : refPm[i];
         best[i]   = 1000;
         bestp0[i] = 0;
      end
      for (int p = 0; p < 4; p++) begin
         for (int u = 0; u < 2; u++) begin
            int p1, p0, c0, c1, bm, nst, cand;
            p1   = (p >> 1) & 1;
            p0   = p & 1;
            c0   = u ^ p1 ^ p0;
            c1   = u ^ p0;
            bm   = ((int'(s0) ^ c0) & 1) + ((int'(s1) ^ c1) & 1);
            nst  = u * 2 + p1;
            cand = oldv[p] + bm;
            if (cand < best[nst]) begin
               best[nst]   = cand;
               bestp0[nst] = p0;
            end
         end
      end
      mn = best[0];
      for (int i = 1; i < 4; i++) if (best[i] < mn) mn = best[i];
      for (int i = 0; i < 4; i++) begin
         refPm[i] = (best[i] - mn > 15) ? 15 : best[i] - mn;
         refD[i]  = bestp0[i];
      end
   endtask

   function automatic logic [15:0] packRefPm();
      return {4'(refPm[0]), 4'(refPm[1]), 4'(refPm[2]), 4'(refPm[3])};
   endfunction

   function automatic logic [3:0] packRefD();
      return {1'(refD[0]), 1'(refD[1]), 1'(refD[2]), 1'(refD[3])};
   endfunction

   // Main sequence: directed table, then randomized stress
   initial begin
      nChecks  = 0;
      nFails   = 0;
      reset    = 1'b0;
      in_valid = 1'b0;
      sof      = 1'b0;
      sym0     = 1'b0;
      sym1     = 1'b0;

      //            rstn  iv    sof   s0    s1    ov    pm           d
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 4'b0000};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 4'b0000};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 4'b0000};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0777, 4'b0000};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0777, 4'b0000};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0777, 4'b0000};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 4'b0000};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0828, 4'b0000};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0828, 4'b0000};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 4'b0000};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0828, 4'b0000};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0301, 4'b0000};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1011, 4'b0001};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h2808, 4'b0000};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 4'b0000};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2808, 4'b0000};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 4'b0000};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 4'b0000};
      vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0828, 4'b0000};
      vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0828, 4'b0000};
      vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0828, 4'b0000};

      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].rstn, vecs[i].iv, vecs[i].sf, vecs[i].s0, vecs[i].s1);
         checkOutput($sformatf("vec%0d", i), vecs[i].expOv, vecs[i].expPm, vecs[i].expD);
      end

      // Randomized stream with idle gaps and occasional frame restarts
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      refPm[0] = 0;
      refPm[1] = 7;
      refPm[2] = 7;
      refPm[3] = 7;
      for (int i = 0; i < 4; i++) refD[i] = 0;
      checkOutput("stress_reset", 1'b0, packRefPm(), packRefD());

      for (int i = 0; i < 10000; i++) begin
         logic iv, sf, s0, s1;
         logic [3:0] mnDut;
         iv = ($urandom_range(0, 3) != 0);
         sf = ($urandom_range(0, 63) == 0);
         s0 = 1'($urandom_range(0, 1));
         s1 = 1'($urandom_range(0, 1));
         applyStimulus(1'b1, iv, sf, s0, s1);
         if (iv) modelStep(s0, s1, sf);
         checkOutput($sformatf("stress%0d", i), iv, packRefPm(), packRefD());
         if (iv) begin
            mnDut = pm0;
            if (pm1 < mnDut) mnDut = pm1;
            if (pm2 < mnDut) mnDut = pm2;
            if (pm3 < mnDut) mnDut = pm3;
            nChecks++;
            if (mnDut !== 4'd0) begin
               nFails++;
               $display("[TB] FAIL stress%0d min_pm: got %0d expected 0", i, mnDut);
            end
         end
      end

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
